// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg: shared register-file widths and the writeback entry type.
package kgp_risc_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W = 32;
   typedef struct packed {
      logic [REG_ADDR_W-1:0] loc;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: 2-write/1-read writeback queue with per-entry location match.
// Optional WB_FWD_EN adds youngest-match data outputs.
module wb_fifo
   import kgp_risc_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_a,
   input  wb_entry_t             a_in,
   input  logic                  push_b,
   input  wb_entry_t             b_in,
   input  logic [REG_ADDR_W-1:0] read_rs,
   input  logic [REG_ADDR_W-1:0] read_rt,
   output logic                  head_valid,
   output wb_entry_t             head,
   output logic [CW-1:0]         count,
   output logic [DEPTH-1:0]      rs_match,
   output logic [DEPTH-1:0]      rt_match
`ifdef WB_FWD_EN
   ,
   output logic [DATA_W-1:0]     rs_fwd,
   output logic [DATA_W-1:0]     rt_fwd
`endif
);
   wb_entry_t mem_q [DEPTH];
   wb_entry_t mem_d [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, wr_b;
   logic [CW-1:0] count_q, count_d;
   logic nonempty, a_store, b_store;
   logic [DEPTH-1:0] live;
   // With an empty queue the head bypasses straight from the inputs, so only the leftovers are stored.
   always_comb begin
      nonempty = count_q != '0;
      head_valid = nonempty || push_a || push_b;
      head = nonempty ? mem_q[rd_q] : (push_a ? a_in : b_in);
      a_store = push_a && nonempty;
      b_store = push_b && (nonempty || push_a);
      wr_b = wr_q + PW'(a_store);
      mem_d = mem_q;
      if (a_store) mem_d[wr_q] = a_in;
      if (b_store) mem_d[wr_b] = b_in;
      wr_d = wr_b + PW'(b_store);
      rd_d = rd_q + PW'(nonempty);
      count_d = count_q + CW'(a_store) + CW'(b_store) - CW'(nonempty);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q <= '0;
         wr_q <= '0;
         count_q <= '0;
      end else begin
         rd_q <= rd_d;
         wr_q <= wr_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) mem_q <= mem_d;
   assign count = count_q;
   for (genvar i = 0; i < DEPTH; i++) begin : g_m
      logic [PW-1:0] age;
      assign age = PW'(i) - rd_q;
      assign live[i] = CW'(age) < count_q;
      assign rs_match[i] = live[i] && mem_q[i].loc == read_rs;
      assign rt_match[i] = live[i] && mem_q[i].loc == read_rt;
   end
`ifdef WB_FWD_EN
   // Walk oldest to youngest so the last hit wins.
   always_comb begin
      rs_fwd = '0;
      rt_fwd = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (rs_match[rd_q + PW'(k)]) rs_fwd = mem_q[rd_q + PW'(k)].data;
         if (rt_match[rd_q + PW'(k)]) rt_fwd = mem_q[rd_q + PW'(k)].data;
      end
   end
`endif
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU and load results into an ordered register write port.
// Optional WB_FWD_EN exposes rs_fwd_data/rt_fwd_data for pending locations.
module writeback_unit
   import kgp_risc_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_loc,
   input  logic [DATA_W-1:0]     alu_data,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [REG_ADDR_W-1:0] ld_loc,
   input  logic [DATA_W-1:0]     ld_data,
   output logic                  write_enable,
   output logic [REG_ADDR_W-1:0] write_loc,
   output logic [DATA_W-1:0]     write_data,
   input  logic [REG_ADDR_W-1:0] read_rs,
   input  logic [REG_ADDR_W-1:0] read_rt,
   output logic                  rs_pending,
   output logic                  rt_pending,
   output logic                  empty,
   output logic [CW-1:0]         count
`ifdef WB_FWD_EN
   ,
   output logic [DATA_W-1:0]     rs_fwd_data,
   output logic [DATA_W-1:0]     rt_fwd_data
`endif
);
   wb_entry_t head;
   logic head_valid;
   logic [DEPTH-1:0] rs_match, rt_match;
   logic write_enable_q, write_enable_d;
   logic [REG_ADDR_W-1:0] write_loc_q, write_loc_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic stage_rs, stage_rt;
`ifdef WB_FWD_EN
   logic [DATA_W-1:0] q_rs_fwd, q_rt_fwd;
`endif
   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_a     (alu_valid),
      .a_in       ('{loc: alu_loc, data: alu_data}),
      .push_b     (ld_valid && ld_ready),
      .b_in       ('{loc: ld_loc, data: ld_data}),
      .read_rs    (read_rs),
      .read_rt    (read_rt),
      .head_valid (head_valid),
      .head       (head),
      .count      (count),
      .rs_match   (rs_match),
      .rt_match   (rt_match)
`ifdef WB_FWD_EN
      ,
      .rs_fwd     (q_rs_fwd),
      .rt_fwd     (q_rt_fwd)
`endif
   );
   // Occupancy limit keeps room for a simultaneous ALU push.
   assign ld_ready = count <= CW'(DEPTH - 2);
   always_comb begin
      write_enable_d = head_valid;
      write_loc_d = head_valid ? head.loc : write_loc_q;
      write_data_d = head_valid ? head.data : write_data_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         write_enable_q <= 1'b0;
         write_loc_q <= '0;
         write_data_q <= '0;
      end else begin
         write_enable_q <= write_enable_d;
         write_loc_q <= write_loc_d;
         write_data_q <= write_data_d;
      end
   end
   assign write_enable = write_enable_q;
   assign write_loc = write_loc_q;
   assign write_data = write_data_q;
   assign stage_rs = write_enable_q && write_loc_q == read_rs;
   assign stage_rt = write_enable_q && write_loc_q == read_rt;
   assign rs_pending = stage_rs || |rs_match;
   assign rt_pending = stage_rt || |rt_match;
   assign empty = count == '0 && !write_enable_q;
`ifdef WB_FWD_EN
   assign rs_fwd_data = |rs_match ? q_rs_fwd : (stage_rs ? write_data_q : '0);
   assign rt_fwd_data = |rt_match ? q_rt_fwd : (stage_rt ? write_data_q : '0);
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed vector table plus hand sequences for hazards and reset.
module tb_writeback_unit;
   logic clk = 1'b0;
   logic rst;
   logic alu_valid, ld_valid, ld_ready, write_enable, rs_pending, rt_pending, empty;
   logic [4:0] alu_loc, ld_loc, write_loc, read_rs, read_rt;
   logic [31:0] alu_data, ld_data, write_data;
   logic [2:0] count;
`ifdef WB_FWD_EN
   logic [31:0] rs_fwd_data, rt_fwd_data;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   writeback_unit #(.DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_loc      (alu_loc),
      .alu_data     (alu_data),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_loc       (ld_loc),
      .ld_data      (ld_data),
      .write_enable (write_enable),
      .write_loc    (write_loc),
      .write_data   (write_data),
      .read_rs      (read_rs),
      .read_rt      (read_rt),
      .rs_pending   (rs_pending),
      .rt_pending   (rt_pending),
      .empty        (empty),
      .count        (count)
`ifdef WB_FWD_EN
      ,
      .rs_fwd_data  (rs_fwd_data),
      .rt_fwd_data  (rt_fwd_data)
`endif
   );

   typedef struct {
      logic av; logic [4:0] al; logic [31:0] ad;
      logic lv; logic [4:0] ll; logic [31:0] ldd;
      logic [4:0] rs; logic [4:0] rt;
      logic we; logic [4:0] wl; logic [31:0] wd; logic [2:0] cnt;
      logic rdy; logic rsp; logic rtp; logic emp;
   } vec_t;
   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] al, input logic [31:0] ad,
                        input logic lv, input logic [4:0] ll, input logic [31:0] ldd,
                        input logic [4:0] rs, input logic [4:0] rt);
      alu_valid = av; alu_loc = al; alu_data = ad;
      ld_valid = lv; ld_loc = ll; ld_data = ldd;
      read_rs = rs; read_rt = rt;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //           av al  ad             lv ll  ldd       rs  rt   we wl  wd             cnt rdy rsp rtp emp
      vecs[0]  = '{1, 5,  32'hA5A5A5A5,  0, 0,  0,        5,  0,   1, 5,  32'hA5A5A5A5,  0,  1,  1,  0,  0};
      vecs[1]  = '{0, 0,  0,             0, 0,  0,        5,  0,   0, 5,  32'hA5A5A5A5,  0,  1,  0,  0,  1};
      vecs[2]  = '{1, 3,  32'h1,         1, 4,  32'h2,    4,  3,   1, 3,  32'h1,         1,  1,  1,  1,  0};
      vecs[3]  = '{0, 0,  0,             0, 0,  0,        4,  3,   1, 4,  32'h2,         0,  1,  1,  0,  0};
      vecs[4]  = '{0, 0,  0,             0, 0,  0,        4,  0,   0, 4,  32'h2,         0,  1,  0,  0,  1};
      vecs[5]  = '{1, 10, 32'h10,        1, 11, 32'h11,   11, 12,  1, 10, 32'h10,        1,  1,  1,  0,  0};
      vecs[6]  = '{1, 12, 32'h12,        1, 13, 32'h13,   13, 10,  1, 11, 32'h11,        2,  1,  1,  0,  0};
      vecs[7]  = '{1, 14, 32'h14,        1, 15, 32'h15,   15, 11,  1, 12, 32'h12,        3,  0,  1,  0,  0};
      vecs[8]  = '{1, 16, 32'h16,        1, 17, 32'h17,   17, 16,  1, 13, 32'h13,        3,  0,  0,  1,  0};
      vecs[9]  = '{0, 0,  0,             1, 17, 32'h17,   17, 15,  1, 14, 32'h14,        2,  1,  0,  1,  0};
      vecs[10] = '{0, 0,  0,             1, 17, 32'h17,   17, 0,   1, 15, 32'h15,        2,  1,  1,  0,  0};
      vecs[11] = '{0, 0,  0,             0, 0,  0,        17, 16,  1, 16, 32'h16,        1,  1,  1,  1,  0};
      vecs[12] = '{0, 0,  0,             0, 0,  0,        17, 0,   1, 17, 32'h17,        0,  1,  1,  0,  0};
      vecs[13] = '{0, 0,  0,             0, 0,  0,        17, 0,   0, 17, 32'h17,        0,  1,  0,  0,  1};
      vecs[14] = '{1, 0,  32'hDEAD0000,  0, 0,  0,        0,  0,   1, 0,  32'hDEAD0000,  0,  1,  1,  1,  0};
      vecs[15] = '{0, 0,  0,             0, 0,  0,        0,  0,   0, 0,  32'hDEAD0000,  0,  1,  0,  0,  1};

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      chk("rst_we", write_enable, 0);
      chk("rst_loc", write_loc, 0);
      chk("rst_data", write_data, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_ready", ld_ready, 1);
      chk("rst_rsp", rs_pending, 0);
      chk("rst_rtp", rt_pending, 0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].av, vecs[i].al, vecs[i].ad, vecs[i].lv, vecs[i].ll, vecs[i].ldd,
               vecs[i].rs, vecs[i].rt);
         step();
         chk($sformatf("v%0d_we", i), write_enable, vecs[i].we);
         chk($sformatf("v%0d_loc", i), write_loc, vecs[i].wl);
         chk($sformatf("v%0d_data", i), write_data, vecs[i].wd);
         chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
         chk($sformatf("v%0d_ready", i), ld_ready, vecs[i].rdy);
         chk($sformatf("v%0d_rsp", i), rs_pending, vecs[i].rsp);
         chk($sformatf("v%0d_rtp", i), rt_pending, vecs[i].rtp);
         chk($sformatf("v%0d_empty", i), empty, vecs[i].emp);
      end

      // Hazard tracking for loc 7 through queue and output stage.
      drive(1, 1, 32'h1, 1, 7, 32'h70, 7, 8);
      step();
      chk("h7a_rsp", rs_pending, 1);
      chk("h7a_rtp", rt_pending, 0);
`ifdef WB_FWD_EN
      chk("h7a_fwd", rs_fwd_data, 32'h70);
      chk("h7a_rtfwd", rt_fwd_data, 0);
`endif
      drive(1, 7, 32'h77, 1, 2, 32'h2, 7, 8);
      step();
      chk("h7b_we", write_enable, 1);
      chk("h7b_loc", write_loc, 7);
      chk("h7b_data", write_data, 32'h70);
      chk("h7b_rsp", rs_pending, 1);
      chk("h7b_rtp", rt_pending, 0);
`ifdef WB_FWD_EN
      chk("h7b_fwd", rs_fwd_data, 32'h77);
`endif
      drive(0, 0, 0, 0, 0, 0, 7, 8);
      step();
      chk("h7c_loc", write_loc, 7);
      chk("h7c_data", write_data, 32'h77);
      chk("h7c_rsp", rs_pending, 1);
`ifdef WB_FWD_EN
      chk("h7c_fwd", rs_fwd_data, 32'h77);
`endif
      step();
      chk("h7d_loc", write_loc, 2);
      chk("h7d_rsp", rs_pending, 0);
      chk("h7d_rtp", rt_pending, 0);
`ifdef WB_FWD_EN
      chk("h7d_fwd", rs_fwd_data, 0);
`endif

      // Reset with three entries queued discards everything.
      drive(1, 20, 32'h20, 1, 21, 32'h21, 23, 24);
      step();
      drive(1, 22, 32'h22, 1, 23, 32'h23, 23, 24);
      step();
      drive(1, 24, 32'h24, 1, 25, 32'h25, 23, 24);
      step();
      chk("pre_rst_count", count, 3);
      chk("pre_rst_rsp", rs_pending, 1);
      rst = 1'b1;
      drive(1, 26, 32'h26, 1, 27, 32'h27, 23, 24);
      step();
      chk("mid_rst_count", count, 0);
      chk("mid_rst_we", write_enable, 0);
      chk("mid_rst_loc", write_loc, 0);
      chk("mid_rst_data", write_data, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_ready", ld_ready, 1);
      chk("mid_rst_rsp", rs_pending, 0);
      chk("mid_rst_rtp", rt_pending, 0);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 23, 24);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("post_rst%0d_we", i), write_enable, 0);
         chk($sformatf("post_rst%0d_empty", i), empty, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter: DEPTH, 4, queue entries (power of two, >=2), excluding the output stage.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: alu_valid  in  1; alu_loc  in  5; alu_data  in  32  ALU result, no backpressure.
REQ-005 SHALL have ports: ld_valid  in  1; ld_ready  out  1; ld_loc  in  5; ld_data  in  32  load result, valid/ready.
REQ-006 SHALL have ports: write_enable  out  1; write_loc  out  5; write_data  out  32  registered; drive the register bank write port.
REQ-007 SHALL have ports: read_rs  in  5; read_rt  in  5; rs_pending  out  1; rt_pending  out  1  hazard query.
REQ-008 SHALL have ports: empty  out  1; count  out  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-009 SHALL accept alu_valid every cycle it is high.
REQ-010 SHALL accept load when ld_valid && ld_ready; ld_ready = (count <= DEPTH-2), combinational from registered count only.
REQ-011 SHALL, when both are accepted in one cycle, order ALU entry before load entry.
REQ-012 SHALL drive write_* from an output stage: each cycle the oldest pending entry moves to it; write_enable=1 for exactly one cycle per entry.
REQ-013 SHALL, with queue empty, present an entry accepted in cycle N on write_* in cycle N+1 (both accepted in N: ALU in N+1, load in N+2).
REQ-014 SHALL retire at most one entry per cycle, strictly FIFO; write_enable=0 and write_loc/write_data hold last value when nothing pending.
REQ-015 SHALL never exceed count = DEPTH-1 given REQ-010; no entry dropped or duplicated.
REQ-016 SHALL assert rs_pending when read_rs matches write_loc of a live output stage (write_enable=1) or any valid queue entry; same for rt; same-cycle inputs not included.
REQ-017 SHALL treat location 0 like any other location (writes and pending).
REQ-018 SHALL compute empty = (count==0) && !write_enable.

Reset
REQ-019 SHALL on rst: count=0, all entries invalid, write_enable=0, write_loc=0, write_data=0, rs/rt_pending=0, empty=1, ld_ready=1.
REQ-020 SHALL on rst mid-operation discard all queued and staged entries; inputs in the reset cycle ignored.

Configuration
REQ-021 SHALL support macro WB_FWD_EN: defined -> extra ports rs_fwd_data, rt_fwd_data (out 32), equal to data of youngest matching entry (queue over output stage) whenever *_pending=1, else 0.
REQ-022 SHALL without WB_FWD_EN omit those ports and forwarding logic; all other behaviour identical.

Structure
REQ-023 SHALL take REG_ADDR_W=5, DATA_W=32 and struct wb_entry_t {loc, data} from shared package kgp_risc_pkg.
REQ-024 SHALL implement the queue as sub-module wb_fifo (2-write/1-read, occupancy, per-entry loc match outputs).

Verification
REQ-025 SHALL test: reset, single alu_valid loc=5 data=0xA5A5A5A5 -> write_enable=1 next cycle with loc 5/data 0xA5A5A5A5, then 0.
REQ-026 SHALL test: ALU(loc 3,0x1) + load(loc 4,0x2) same cycle -> writes loc 3 then loc 4 in consecutive cycles.
REQ-027 SHALL test: ALU+load every cycle, DEPTH=4 -> ld_ready drops at count=3, no loss, write order equals acceptance order.
REQ-028 SHALL test: queued loc 7 with read_rs=7 -> rs_pending=1 until write_enable cycle ends; read_rt=8 -> rt_pending=0; with WB_FWD_EN rs_fwd_data = youngest loc-7 data.
REQ-029 SHALL test: rst asserted with 3 entries queued -> next cycle count=0, write_enable=0, no further writes.
